// File: rtl/flash_async_port.sv
// Request/ready responder that runs asynchronous read/write cycles on the shared Nexys2 Flash bus.
// Optional FLASH_PAGE_MODE_EN: keep the read page open and serve in-page reads in PAGE_WAIT cycles.

module flash_async_port #(
  parameter int READ_WAIT    = 7,
  parameter int PAGE_WAIT    = 2,
  parameter int WRITE_WAIT   = 4,
  parameter int RESET_CYCLES = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [22:0] p_address,
  input  logic [15:0] p_to_mem,
  output logic [15:0] p_from_mem,
  input  logic        p_req,
  input  logic        p_wren,
  output logic        p_ready,
  output logic [22:0] shared_a,
  inout  wire  [15:0] shared_d,
  output logic        shared_oe_n,
  output logic        shared_we_n,
  output logic        flash_ce_n,
  output logic        flash_reset_n,
  input  logic        flash_sts
);

`ifdef FLASH_PAGE_MODE_EN
  localparam bit PAGE_MODE = 1'b1;
`else
  localparam bit PAGE_MODE = 1'b0;
`endif

  localparam logic [15:0] RD_LAST  = 16'(READ_WAIT - 1);
  localparam logic [15:0] PG_LAST  = 16'(PAGE_WAIT - 1);
  localparam logic [15:0] WR_LAST  = 16'(WRITE_WAIT - 1);
  localparam logic [15:0] RST_LAST = 16'(RESET_CYCLES - 1);
  localparam logic [15:0] BOOT_TMO = 16'hFFFE;

  typedef enum logic [2:0] {
    BOOT_RST, BOOT_WAIT, IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD
  } state_t;

  state_t      state;
  logic [15:0] cnt;
  logic [15:0] rd_last;
  logic        closing;
  logic        page_open;
  logic        drive_en;
  logic [15:0] wdata;
  logic        pend_valid;
  logic [22:0] pend_addr;
  logic        pend_wren;
  logic [15:0] pend_data;

  logic        done_now;
  logic        launch;
  logic        page_live;
  logic        page_hit;
  logic [22:0] nxt_addr;
  logic        nxt_wren;
  logic [15:0] nxt_data;

  assign shared_d = drive_en ? wdata : 16'bz;

  // NOTE: every always_comb output is given a default first so no latch can be inferred.
  always_comb begin
    nxt_addr = pend_addr;
    nxt_wren = pend_wren;
    nxt_data = pend_data;
    if (p_req) begin
      nxt_addr = p_address;
      nxt_wren = p_wren;
      nxt_data = p_to_mem;
    end
    done_now  = ((state == RD) && !closing && (cnt == rd_last)) || (state == WR_HOLD);
    launch    = ((state == IDLE) || done_now) && (p_req || pend_valid);
    // The page is "live" while idling after a read, or at the edge a read finishes.
    page_live = PAGE_MODE && (((state == IDLE) && page_open) || ((state == RD) && done_now));
    page_hit  = page_live && !nxt_wren && (nxt_addr[22:2] == shared_a[22:2]);
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and clears the pending slot too, so an aborted request never replays.
    if (rst) begin
      state         <= BOOT_RST;
      cnt           <= '0;
      rd_last       <= RD_LAST;
      closing       <= 1'b0;
      page_open     <= 1'b0;
      drive_en      <= 1'b0;
      wdata         <= '0;
      pend_valid    <= 1'b0;
      pend_addr     <= '0;
      pend_wren     <= 1'b0;
      pend_data     <= '0;
      p_ready       <= 1'b0;
      p_from_mem    <= '0;
      shared_a      <= '0;
      flash_ce_n    <= 1'b1;
      shared_oe_n   <= 1'b1;
      shared_we_n   <= 1'b1;
      flash_reset_n <= 1'b0;
    end else begin
      if (launch) begin
        pend_valid <= 1'b0;
      end else if (p_req) begin
        pend_valid <= 1'b1;
        pend_addr  <= p_address;
        pend_wren  <= p_wren;
        pend_data  <= p_to_mem;
      end

      case (state)
        BOOT_RST: begin
          if (cnt == RST_LAST) begin
            state         <= BOOT_WAIT;
            cnt           <= '0;
            flash_reset_n <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        BOOT_WAIT: begin
          if (flash_sts || (cnt == BOOT_TMO)) begin
            state   <= IDLE;
            p_ready <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        IDLE: ;
        RD: begin
          if (closing) begin
            closing     <= 1'b0;
            flash_ce_n  <= 1'b0;
            shared_oe_n <= 1'b0;
          end else if (done_now) begin
            p_from_mem <= shared_d;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        WR_SETUP: begin
          state       <= WR_PULSE;
          shared_we_n <= 1'b0;
          cnt         <= '0;
        end
        WR_PULSE: begin
          if (cnt == WR_LAST) begin
            state       <= WR_HOLD;
            shared_we_n <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        WR_HOLD: ;
        default: state <= IDLE;
      endcase

      // NOTE: non-blocking assignments; the completion and launch blocks below intentionally
      // override the per-state assignments above (the last assignment in the block wins).
      if (done_now) begin
        state    <= IDLE;
        p_ready  <= 1'b1;
        drive_en <= 1'b0;
        if (PAGE_MODE && (state == RD)) begin
          page_open <= 1'b1;
        end else begin
          flash_ce_n  <= 1'b1;
          shared_oe_n <= 1'b1;
        end
      end

      if (launch) begin
        p_ready    <= 1'b0;
        shared_a   <= nxt_addr;
        cnt        <= '0;
        flash_ce_n <= 1'b0;
        if (nxt_wren) begin
          state       <= WR_SETUP;
          shared_oe_n <= 1'b1;
          drive_en    <= 1'b1;
          wdata       <= nxt_data;
          page_open   <= 1'b0;
        end else begin
          state    <= RD;
          drive_en <= 1'b0;
          rd_last  <= page_hit ? PG_LAST : RD_LAST;
          if (page_live && !page_hit) begin
            // Page miss: spend one cycle with CE/OE released before the full access.
            closing     <= 1'b1;
            flash_ce_n  <= 1'b1;
            shared_oe_n <= 1'b1;
            page_open   <= 1'b0;
          end else begin
            shared_oe_n <= 1'b0;
          end
        end
      end
    end
  end

endmodule
